// File: rtl/rr_mux_n.sv
// Purpose: N-channel registered mux with round-robin, fixed-priority or direct-select arbitration.
// Latency: one cycle from an input transfer to out_valid; sustains one word per cycle.
// Backpressure: while out_valid && !out_ready the output holds and every in_ready is low.
module rr_mux_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [SEL_W-1:0]    rr_ptr;
  logic [CHANNELS-1:0] grant;
  logic                can_accept;
  logic                xfer;
  logic [SEL_W-1:0]    gidx;
  logic [SEL_W-1:0]    nxt_ptr;
  logic [WIDTH-1:0]    gdata;
  int                  best_d;

  // Pick at most one requesting channel according to the arbitration mode.
  always_comb begin
    grant  = '0;
    best_d = CHANNELS;
    if (MODE == 0) begin
      // Distance of each channel from rr_ptr, walking upward with wrap;
      // the nearest requester wins.
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_valid[i] && ((i + CHANNELS - int'(rr_ptr)) % CHANNELS) < best_d)
          best_d = (i + CHANNELS - int'(rr_ptr)) % CHANNELS;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        grant[i] = in_valid[i] && (((i + CHANNELS - int'(rr_ptr)) % CHANNELS) == best_d);
      end
    end else if (MODE == 1) begin
      // Lowest-index requester wins.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i])
          best_d = i;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        grant[i] = in_valid[i] && (i == best_d);
      end
    end else begin
      // Direct select looks only at the selected channel's own request;
      // out-of-range selects match no channel.
      for (int i = 0; i < CHANNELS; i++) begin
        grant[i] = (int'(sel) == i) && in_valid[i];
      end
    end
  end

  // Encode the granted channel index, its data word and the next round-robin pointer.
  always_comb begin
    gidx    = '0;
    gdata   = '0;
    nxt_ptr = rr_ptr;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        gidx    = SEL_W'(i);
        gdata   = in_data[i*WIDTH +: WIDTH];
        nxt_ptr = (i == CHANNELS - 1) ? '0 : SEL_W'(i + 1);
      end
    end
  end

  // Accept when the output stage is empty or draining this cycle; silent in reset.
  always_comb begin
    can_accept = !out_valid || out_ready;
    in_ready   = {CHANNELS{can_accept && !reset}} & grant;
    xfer       = |(in_valid & in_ready);
  end

  // Single output register: refill on transfer, otherwise drop valid when drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_data  <= gdata;
        out_chan  <= gidx;
        out_valid <= 1'b1;
        if (MODE == 0)
          rr_ptr <= nxt_ptr;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n: one instance per mode plus a 3-channel direct-select
// instance that can see out-of-range select values.
module tb_rr_mux_n;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_valid;
  logic [1:0]   sel;
  logic         out_ready;

  logic [3:0]   rdy0, rdy1, rdy2;
  logic [2:0]   rdy3;
  logic [W-1:0] od0, od1, od2, od3;
  logic [1:0]   oc0, oc1, oc2, oc3;
  logic         ov0, ov1, ov2, ov3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_n #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .sel(sel), .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(out_ready));
  rr_mux_n #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .sel(sel), .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(out_ready));
  rr_mux_n #(.WIDTH(W), .CHANNELS(4), .SEL_W(2), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
    .sel(sel), .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(out_ready));
  rr_mux_n #(.WIDTH(W), .CHANNELS(3), .SEL_W(2), .MODE(2)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data[3*W-1:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
    .sel(sel), .out_data(od3), .out_chan(oc3), .out_valid(ov3), .out_ready(out_ready));

  typedef struct {
    logic [3:0] v;
    logic [1:0] s;
    logic [3:0] r0;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [2:0] r3;
  } vec_t;

  vec_t tbl [12];
  int   ec [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] x);
    int r = 0;
    for (int i = 0; i < 4; i++) if (x[i]) r = i;
    return r;
  endfunction

  function automatic logic [3:0] exp_rdy(input int d, input vec_t t);
    case (d)
      0: return t.r0;
      1: return t.r1;
      2: return t.r2;
      default: return {1'b0, t.r3};
    endcase
  endfunction

  function automatic logic [W-1:0] get_od(input int d);
    case (d)
      0: return od0;
      1: return od1;
      2: return od2;
      default: return od3;
    endcase
  endfunction

  function automatic logic [1:0] get_oc(input int d);
    case (d)
      0: return oc0;
      1: return oc1;
      2: return oc2;
      default: return oc3;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  initial begin
    //          valid    sel    rr       prio     direct   direct(3ch)
    tbl[0]  = '{4'b1111, 2'd0, 4'b0001, 4'b0001, 4'b0001, 3'b001};
    tbl[1]  = '{4'b1111, 2'd1, 4'b0010, 4'b0001, 4'b0010, 3'b010};
    tbl[2]  = '{4'b1111, 2'd2, 4'b0100, 4'b0001, 4'b0100, 3'b100};
    tbl[3]  = '{4'b1111, 2'd3, 4'b1000, 4'b0001, 4'b1000, 3'b000};
    tbl[4]  = '{4'b1111, 2'd0, 4'b0001, 4'b0001, 4'b0001, 3'b001};
    tbl[5]  = '{4'b1111, 2'd1, 4'b0010, 4'b0001, 4'b0010, 3'b010};
    tbl[6]  = '{4'b0100, 2'd3, 4'b0100, 4'b0100, 4'b0000, 3'b000};
    tbl[7]  = '{4'b0010, 2'd1, 4'b0010, 4'b0010, 4'b0010, 3'b010};
    tbl[8]  = '{4'b1010, 2'd3, 4'b1000, 4'b0010, 4'b1000, 3'b000};
    tbl[9]  = '{4'b1010, 2'd0, 4'b0010, 4'b0010, 4'b0000, 3'b000};
    tbl[10] = '{4'b0000, 2'd0, 4'b0000, 4'b0000, 4'b0000, 3'b000};
    tbl[11] = '{4'b1111, 2'd3, 4'b0100, 4'b0001, 4'b1000, 3'b000};

    reset     = 1'b1;
    in_valid  = '0;
    sel       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(i + 1);
    #1;
    chk("reset_ov0", {31'd0, ov0}, 32'd0);
    chk("reset_od2", od2, 32'd0);
    chk("reset_oc1", {30'd0, oc1}, 32'd0);
    chk("reset_rdy0", {28'd0, rdy0}, 32'd0);
    chk("reset_ptr", {30'd0, u0.rr_ptr}, 32'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 4; d++) ec[d] = 0;

    // Table: out_ready stays high, so in_ready equals the grant every cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v;
      sel      = tbl[i].s;
      #1;
      chk($sformatf("row%0d_rdy0", i), {28'd0, rdy0}, {28'd0, tbl[i].r0});
      chk($sformatf("row%0d_rdy1", i), {28'd0, rdy1}, {28'd0, tbl[i].r1});
      chk($sformatf("row%0d_rdy2", i), {28'd0, rdy2}, {28'd0, tbl[i].r2});
      chk($sformatf("row%0d_rdy3", i), {29'd0, rdy3}, {29'd0, tbl[i].r3});
      @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) begin
        if (exp_rdy(d, tbl[i]) != 4'b0000) ec[d] = oh2i(exp_rdy(d, tbl[i]));
        chk($sformatf("row%0d_ov%0d", i, d), {31'd0, get_ov(d)},
            {31'd0, exp_rdy(d, tbl[i]) != 4'b0000});
        chk($sformatf("row%0d_oc%0d", i, d), {30'd0, get_oc(d)}, 32'(ec[d]));
        chk($sformatf("row%0d_od%0d", i, d), get_od(d), 32'(ec[d] + 1));
      end
    end

    // Backpressure: load ch2 (word 3) into the direct-select instance, then stall.
    @(negedge clk);
    in_valid = 4'b1111;
    sel      = 2'd2;
    @(posedge clk);
    #1;
    chk("bp_load_od2", od2, 32'd3);
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_rdy2", c), {28'd0, rdy2}, 32'd0);
      chk($sformatf("bp%0d_rdy0", c), {28'd0, rdy0}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_od2", c), od2, 32'd3);
      chk($sformatf("bp%0d_oc2", c), {30'd0, oc2}, 32'd2);
      chk($sformatf("bp%0d_ov2", c), {31'd0, ov2}, 32'd1);
      @(negedge clk);
    end
    // Release with a new ch0 word: drain and refill in the same edge.
    in_data[0 +: W] = 32'h0000_00AA;
    sel             = 2'd0;
    out_ready       = 1'b1;
    #1;
    chk("refill_rdy2", {28'd0, rdy2}, 32'b0001);
    @(posedge clk);
    #1;
    chk("refill_od2", od2, 32'h0000_00AA);
    chk("refill_oc2", {30'd0, oc2}, 32'd0);
    chk("refill_ov2", {31'd0, ov2}, 32'd1);

    // Asynchronous reset mid-stream, checked before any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ov2", {31'd0, ov2}, 32'd0);
    chk("arst_od2", od2, 32'd0);
    chk("arst_oc2", {30'd0, oc2}, 32'd0);
    chk("arst_rdy0", {28'd0, rdy0}, 32'd0);
    chk("arst_ptr", {30'd0, u0.rr_ptr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_rdy0", {28'd0, rdy0}, 32'b0001);
    @(posedge clk);
    #1;
    chk("post_rst_oc0", {30'd0, oc0}, 32'd0);
    chk("post_rst_od0", od0, 32'h0000_00AA);

    // Round-robin search wrap: from rr_ptr=0 only ch2, then only ch1.
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 4'b0100;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rr_ch2_rdy0", {28'd0, rdy0}, 32'b0100);
    @(posedge clk);
    #1;
    chk("rr_ch2_od0", od0, 32'd3);
    chk("rr_ch2_oc0", {30'd0, oc0}, 32'd2);
    chk("rr_ch2_ptr", {30'd0, u0.rr_ptr}, 32'd3);
    @(negedge clk);
    in_valid = 4'b0010;
    #1;
    chk("rr_ch1_rdy0", {28'd0, rdy0}, 32'b0010);
    @(posedge clk);
    #1;
    chk("rr_ch1_od0", od0, 32'd2);
    chk("rr_ch1_oc0", {30'd0, oc0}, 32'd1);
    chk("rr_ch1_ptr", {30'd0, u0.rr_ptr}, 32'd2);
    @(negedge clk);
    in_valid = 4'b0000;
    @(posedge clk);
    #1;
    chk("drain_ov0", {31'd0, ov0}, 32'd0);
    chk("drain_oc0", {30'd0, oc0}, 32'd1);
    chk("drain_ptr", {30'd0, u0.rr_ptr}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
